uart_rx_core: RTL
=================

Name: uart_rx_core

Overview:
- Serial receiver that accepts the exact frame format our tx_engine produces: 1 start bit, 7 or 8 data bits LSB first, optional parity, 1 stop bit, with the bit time set by the shared baud divisor k.
- Sits at the far end of the serial link, for example in a loopback test fixture or a second UART node.
- Presents the received byte and error flags to a TramelBlaze-style port interface.
- Uses the same rxrdy/clr read handshake as the UART status port.

Parameters:
- KW, 19, width of the baud divisor k; must match the top-level baud table.
- SYNC_STAGES, 2, number of flip-flop stages synchronising rx into clk; legal values 2 to 3.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- rx  in  1  serial line; idles high.
- eight  in  1  1 = 8 data bits, 0 = 7 data bits.
- pen  in  1  1 = parity bit present.
- ohel  in  1  parity sense: 1 = odd, 0 = even.
- k  in  KW  clock cycles per bit; must be at least 4.
- clr  in  1  one-cycle read strobe; clears the flags below.
- data  out  8  received byte; bit 7 is 0 in 7-bit mode.
- rxrdy  out  1  a new byte is available.
- perr  out  1  parity error on the byte in data.
- ferr  out  1  framing error (stop bit sampled as 0).
- ovf  out  1  a byte completed while rxrdy was still 1.

Behaviour:
- Reset (reset_n = 0, asynchronous):
  - State goes to IDLE and all counters clear.
  - Synchroniser flops are set to 1.
  - data = 0x00; rxrdy, perr, ferr and ovf = 0.
- Configuration capture: eight, pen, ohel and k are latched on the IDLE to START transition and held for the whole frame. Changing them mid-frame has no effect until the next frame.
- Frame length: N = 7 + eight + pen bits after the start bit, then the stop bit.
- States:
  - IDLE: when synced rx = 0 (call this cycle T0), load the bit timer with k >> 1 and go to START.
  - START: when the timer expires (sample point at T0 + k/2), re-sample rx.
    - rx = 1: false start; go to IDLE with no flag change.
    - rx = 0: load the timer with k, clear the bit counter, go to DATA.
  - DATA: sample each time the timer expires, i.e. at T0 + k/2 + n*k for n = 1..(7 + eight).
    - Shift the sample in at the MSB of a right-shift register.
    - After the last data bit, go to PARITY if pen = 1, otherwise to STOP.
  - PARITY: sample the parity bit p.
    - Expected value is XOR of the received data bits when ohel = 0, and its inverse when ohel = 1.
    - Register a mismatch internally.
  - STOP: sample the stop bit. On the cycle after the sample:
    - data <= the assembled byte (7-bit mode right-aligned, bit 7 = 0).
    - rxrdy <= 1.
    - perr <= the registered mismatch (0 if pen = 0).
    - ferr <= ~stop_sample.
    - ovf <= rxrdy (old value).
    - If stop_sample = 1, go to IDLE.
    - If stop_sample = 0, go to BREAK.
  - BREAK: wait until synced rx = 1, then go to IDLE. This stops a held-low line from retriggering reception.
- clr:
  - On the clock after clr = 1, rxrdy, perr, ferr and ovf go to 0.
  - data holds its value.
- clr in the same cycle as a frame completion: the completion wins. rxrdy = 1, ferr and perr come from the new frame, and ovf = 0 (the previous byte counts as read).
- Latency: with M = 7 + eight + pen, rxrdy rises at T0 + k/2 + (M + 1)*k + 1 cycles. The synchroniser adds SYNC_STAGES cycles relative to the raw rx pin.
- Timer arithmetic:
  - KW-bit down-counter; it expires on the cycle it reaches 1, and the sample is taken that cycle.
  - k >> 1 truncates, so odd k samples one cycle early. This is accepted.
  - k < 4 is unsupported. Implementations clamp the effective k to 4.
- Only the rx path changes state. A glitch shorter than k/2 produces no output.

Decomposition:
- Package uart_pkg:
  - State encoding localparams: IDLE, START, DATA, PARITY, STOP, BREAK.
  - KW.
  - KMIN = 4.
  - Baud divisor table constants for baud codes 0..11, shared with the top level.
- Natural sub-module: uart_bit_timer.
  - Loadable down-counter with load_half and load_full inputs and a tick output.
  - Reusable later by tx_engine.

Test Plan:
1. 8N1, k = 16, rx frame 0xA5 → rxrdy = 1 at T0 + 8 + 9*16 + 1; data = 0xA5; perr = ferr = ovf = 0.
2. 7E1 (eight = 0, pen = 1, ohel = 0), byte 0x53 with parity 0 → data = 0x53, perr = 0. Repeat with parity 1 → perr = 1.
3. 8O1 (ohel = 1), byte 0x00 with parity 1 → perr = 0. Then send the stop bit as 0 and hold rx low for 3k → ferr = 1; no second rxrdy edge until rx has returned high and a new start arrives.
4. Two 8N1 frames 0x11 then 0x22 with no clr → data = 0x22, ovf = 1. Pulse clr → next cycle rxrdy = perr = ferr = ovf = 0 and data stays 0x22. Then clr coincident with completion of 0x33 → rxrdy = 1, ovf = 0.
5. Glitch: rx low for 3 cycles with k = 16 → rxrdy stays 0 and the state returns to IDLE. A valid frame 0x5A immediately afterwards is received correctly.
6. Pull reset_n low in the middle of DATA → all outputs are 0 in the same cycle, asynchronously. Release reset; the next 8N1 frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART blocks: divisor width, receiver states and the
// baud divisor table (100 MHz clk_sys, k = clocks per bit).
package uart_pkg;

    localparam int KW   = 19;
    localparam int KMIN = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_e;

    function automatic logic [KW-1:0] baud_k(input logic [3:0] code);
        case (code)
            4'd0:    return KW'(333333);  // 300
            4'd1:    return KW'(166667);  // 600
            4'd2:    return KW'(83333);   // 1200
            4'd3:    return KW'(41667);   // 2400
            4'd4:    return KW'(20833);   // 4800
            4'd5:    return KW'(10417);   // 9600
            4'd6:    return KW'(5208);    // 19200
            4'd7:    return KW'(2604);    // 38400
            4'd8:    return KW'(1736);    // 57600
            4'd9:    return KW'(868);     // 115200
            4'd10:   return KW'(434);     // 230400
            4'd11:   return KW'(217);     // 460800
            default: return KW'(868);
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Port bundle between the receiver core and its host: serial line, frame
// configuration, read strobe, received byte and status flags.
interface uart_rx_core_if #(
    parameter int KW = uart_pkg::KW
);
    logic          rx;
    logic          eight;
    logic          pen;
    logic          ohel;
    logic [KW-1:0] k;
    logic          clr;
    logic [7:0]    data;
    logic          rxrdy;
    logic          perr;
    logic          ferr;
    logic          ovf;

    modport master (
        output rx, eight, pen, ohel, k, clr,
        input  data, rxrdy, perr, ferr, ovf
    );

    modport slave (
        input  rx, eight, pen, ohel, k, clr,
        output data, rxrdy, perr, ferr, ovf
    );
endinterface

// File: rtl/uart_bit_timer.sv
// Loadable bit-period down-counter; tick is asserted on the cycle the count is 1.
// Idles at 0 once expired until reloaded.
module uart_bit_timer #(
    parameter int KW = 19
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [KW-1:0] k,
    input  logic          load_half,
    input  logic          load_full,
    output logic          tick
);

    logic [KW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_full)
            cnt_d = k;
        else if (load_half)
            cnt_d = k >> 1;
        else if (cnt_q != '0)
            cnt_d = cnt_q - KW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == KW'(1));

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: start, 7/8 data bits LSB first, optional parity, one stop bit,
// with rxrdy/clr read handshake and parity/framing/overrun flags.
//
// state  | meaning
// IDLE   | line high, waiting for a start edge
// START  | half a bit in, confirming the start bit
// DATA   | sampling data bits into the shift register
// PARITY | sampling and checking the parity bit
// STOP   | sampling the stop bit, publishing the byte
// BREAK  | stop bit was low, waiting for the line to go high
module uart_rx_core #(
    parameter int KW          = uart_pkg::KW,
    parameter int SYNC_STAGES = 2
) (
    input logic           clk,
    input logic           reset_n,
    uart_rx_core_if.slave bus
);
    import uart_pkg::*;

    localparam logic [KW-1:0] K_MIN = KW'(KMIN);

    rx_state_e              state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [7:0]             shift_q, shift_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   eight_q, eight_d, pen_q, pen_d, ohel_q, ohel_d;
    logic [KW-1:0]          k_q, k_d;
    logic                   par_err_q, par_err_d;
    logic [7:0]             data_q, data_d;
    logic                   rxrdy_q, rxrdy_d, perr_q, perr_d;
    logic                   ferr_q, ferr_d, ovf_q, ovf_d;

    logic                   rx_s, tick, load_half, load_full;
    logic [KW-1:0]          k_live, k_timer;
    logic [7:0]             byte_asm;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], bus.rx};
    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign k_live   = (bus.k < K_MIN) ? K_MIN : bus.k;
    // The half-bit load happens on the same edge the configuration is captured.
    assign k_timer  = (state_q == IDLE) ? k_live : k_q;
    assign byte_asm = eight_q ? shift_q : {1'b0, shift_q[7:1]};

    uart_bit_timer #(.KW(KW)) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .k         (k_timer),
        .load_half (load_half),
        .load_full (load_full),
        .tick      (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        eight_d   = eight_q;
        pen_d     = pen_q;
        ohel_d    = ohel_q;
        k_d       = k_q;
        par_err_d = par_err_q;
        data_d    = data_q;
        rxrdy_d   = rxrdy_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        ovf_d     = ovf_q;
        load_half = 1'b0;
        load_full = 1'b0;

        if (bus.clr) begin
            rxrdy_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            ovf_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    load_half = 1'b1;
                    eight_d   = bus.eight;
                    pen_d     = bus.pen;
                    ohel_d    = bus.ohel;
                    k_d       = k_live;
                    state_d   = START;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        load_full = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    load_full = 1'b1;
                    shift_d   = {rx_s, shift_q[7:1]};
                    if (bit_cnt_q == {2'b11, eight_q})
                        state_d = pen_q ? PARITY : STOP;
                    else
                        bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            PARITY: begin
                if (tick) begin
                    load_full = 1'b1;
                    par_err_d = rx_s ^ (^byte_asm) ^ ohel_q;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    data_d  = byte_asm;
                    rxrdy_d = 1'b1;
                    perr_d  = pen_q & par_err_q;
                    ferr_d  = ~rx_s;
                    // A clr landing with the completion means the old byte was read.
                    ovf_d   = rxrdy_q & ~bus.clr;
                    state_d = rx_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rx_s)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sync_q    <= '1;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            eight_q   <= 1'b0;
            pen_q     <= 1'b0;
            ohel_q    <= 1'b0;
            k_q       <= '0;
            par_err_q <= 1'b0;
            data_q    <= '0;
            rxrdy_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            eight_q   <= eight_d;
            pen_q     <= pen_d;
            ohel_q    <= ohel_d;
            k_q       <= k_d;
            par_err_q <= par_err_d;
            data_q    <= data_d;
            rxrdy_q   <= rxrdy_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.data  = data_q;
    assign bus.rxrdy = rxrdy_q;
    assign bus.perr  = perr_q;
    assign bus.ferr  = ferr_q;
    assign bus.ovf   = ovf_q;

endmodule
